// File: rtl/ifetch_if.sv
// ifetch_if: pipeline control, instruction-memory channel and IF/ID output of the fetch unit
interface ifetch_if #(
   parameter int XLEN = 32
);
   logic            pause;
   logic            jump;
   logic [XLEN-1:0] jump_addr;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            out_valid;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_inst;
   modport master (
      input  pause, jump, jump_addr, imem_ready, imem_rvalid, imem_rdata,
      output imem_req, imem_addr, out_valid, out_pc, out_inst
   );
   modport slave (
      output pause, jump, jump_addr, imem_ready, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr, out_valid, out_pc, out_inst
   );
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential PC generator with credit-based prefetch FIFO and redirect flush
module ifetch_buffer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input logic      clk,
   input logic      rst,
   ifetch_if.master bus
);
   localparam int          AW  = $clog2(DEPTH);
   localparam int          CW  = AW + 1;
   localparam logic [31:0] NOP = 32'h00000013;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   drop;
   logic [CW:0]     used;
   logic            accept;
   logic            push;
   logic            pop;

   // credit check, handshakes and in-flight count after this cycle's accept/response
   always_comb begin
      used             = {1'b0, count} + {1'b0, outstanding};
      bus.imem_req     = !rst && !bus.jump && (used < (CW+1)'(DEPTH));
      accept           = bus.imem_req && bus.imem_ready;
      push             = bus.imem_rvalid && drop == '0 && !bus.jump;
      pop              = bus.out_valid && !bus.pause && !bus.jump;
      outstanding_next = outstanding + CW'(accept) - CW'(bus.imem_rvalid);
      target           = bus.jump_addr & ~XLEN'(3);
   end

   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = count != '0;
   assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr] : '0;
   assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr] : NOP;

   // control state; resp_pc is the pc of the next kept response, restarted at every redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (bus.jump) begin
            fetch_pc <= target;
            resp_pc  <= target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop     <= outstanding_next;
         end else begin
            if (accept) fetch_pc <= fetch_pc + XLEN'(4);
            if (push) begin
               resp_pc <= resp_pc + XLEN'(4);
               wr_ptr  <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (bus.imem_rvalid && drop != '0) drop <= drop - CW'(1);
         end
      end
   end

   // FIFO payload storage, only read while the entry is valid
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         inst_mem[wr_ptr] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: randomized self-checking bench with in-order memory model and pc-stream reference
module tb_ifetch_buffer;
   localparam logic [31:0] NOP = 32'h00000013;
   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   req_t        mq[$];
   int          cyc = 0;
   int          lat = 1;
   int          total = 0;
   int          bad = 0;
   bit          rand_rdy = 1'b0;
   logic [31:0] exp_pc = '0;

   ifetch_if #(.XLEN(32)) bus ();
   ifetch_buffer #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   // instruction memory: in-order responses lat cycles after acceptance, reset together with the DUT
   always @(posedge clk) begin
      if (rst) mq.delete();
      else begin
         if (bus.imem_rvalid) void'(mq.pop_front());
         if (bus.imem_req && bus.imem_ready) mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
      end
      cyc++;
      #1;
      bus.imem_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.imem_rvalid = !rst && mq.size() != 0 && mq[0].due <= cyc;
      bus.imem_rdata  = bus.imem_rvalid ? word(mq[0].addr) : $urandom;
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP})
         begin bad++; $display("FAIL reset_values req=%b addr=%h valid=%b pc=%h inst=%h", bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_inst); end
      next();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.out_valid !== 1'b0)
         begin bad++; $display("FAIL cycle0 req=%b addr=%h valid=%b expected 1 00000000 0", bus.imem_req, bus.imem_addr, bus.out_valid); end
      next();
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL cycle1_valid got %b expected 0", bus.out_valid); end
      next();
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== word(32'h0))
         begin bad++; $display("FAIL cycle2_first valid=%b pc=%h inst=%h expected 1 00000000 %h", bus.out_valid, bus.out_pc, bus.out_inst, word(32'h0)); end
      exp_pc = 32'h4;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 16; i++) begin
         next();
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
            begin bad++; $display("FAIL stream valid=%b pc=%h inst=%h expected 1 %h %h", bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
         exp_pc += 4;
      end
   endtask

   task automatic test_pause();
      for (int i = 0; i < 6; i++) begin
         next();
         bus.pause = 1'b1;
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc)
            begin bad++; $display("FAIL pause_hold valid=%b pc=%h expected 1 %h", bus.out_valid, bus.out_pc, exp_pc); end
         if (i >= 3) begin
            total++;
            if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL pause_full_req got %b expected 0", bus.imem_req); end
         end
      end
      for (int i = 0; i < 12; i++) begin
         next();
         bus.pause = 1'b0;
         @(negedge clk);
         if (i < 2) begin
            total++;
            if (bus.imem_req !== 1'(i)) begin bad++; $display("FAIL release_req step=%0d got %b expected %0d", i, bus.imem_req, i); end
         end
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
            begin bad++; $display("FAIL pause_release valid=%b pc=%h inst=%h expected 1 %h %h", bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
         exp_pc += 4;
      end
   endtask

   task automatic test_jump_lat3();
      int n;
      lat = 3;
      for (int i = 0; i < 20; i++) begin
         next();
         if (i >= 10 && mq.size() == 3) break;
         @(negedge clk);
         if (bus.out_valid) begin
            total++;
            if (bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
               begin bad++; $display("FAIL lat3_stream pc=%h inst=%h expected %h %h", bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
            exp_pc += 4;
         end
      end
      bus.jump      = 1'b1;
      bus.jump_addr = 32'h100;
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL jump_cycle_req got %b expected 0", bus.imem_req); end
      exp_pc = 32'h100;
      next();
      bus.jump = 1'b0;
      n = 1;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         next();
         n++;
         @(negedge clk);
      end
      total++;
      if (n != 5 || bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
         begin bad++; $display("FAIL jump_target cycles=%0d pc=%h inst=%h expected 5 %h %h", n, bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
      exp_pc += 4;
      for (int i = 0; i < 10; i++) begin
         next();
         @(negedge clk);
         if (bus.out_valid) begin
            total++;
            if (bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
               begin bad++; $display("FAIL after_jump pc=%h inst=%h expected %h %h", bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
            exp_pc += 4;
         end
      end
   endtask

   task automatic test_jump_pause();
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         next();
         if (i >= 8 && bus.imem_rvalid) break;
         @(negedge clk);
         if (bus.out_valid) begin
            total++;
            if (bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
               begin bad++; $display("FAIL pre_jp_stream pc=%h inst=%h expected %h %h", bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
            exp_pc += 4;
         end
      end
      total++;
      if (bus.imem_rvalid !== 1'b1) begin bad++; $display("FAIL jp_response_present got %b expected 1", bus.imem_rvalid); end
      bus.pause     = 1'b1;
      bus.jump      = 1'b1;
      bus.jump_addr = 32'h203;
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL jp_cycle_req got %b expected 0", bus.imem_req); end
      next();
      bus.pause = 1'b0;
      bus.jump  = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1)
         begin bad++; $display("FAIL jp_next valid=%b addr=%h req=%b expected 0 00000200 1", bus.out_valid, bus.imem_addr, bus.imem_req); end
      next();
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL jp_n2_valid got %b expected 0", bus.out_valid); end
      exp_pc = 32'h200;
      for (int i = 0; i < 6; i++) begin
         next();
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
            begin bad++; $display("FAIL jp_stream valid=%b pc=%h inst=%h expected 1 %h %h", bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
         exp_pc += 4;
      end
   endtask

   task automatic test_ready_random();
      logic        prev_req = 1'b0;
      logic        prev_rdy = 1'b0;
      logic [31:0] prev_addr = '0;
      rand_rdy = 1'b1;
      lat      = 2;
      for (int i = 0; i < 200; i++) begin
         next();
         bus.pause = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         if (prev_req && !prev_rdy) begin
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)
               begin bad++; $display("FAIL addr_stable req=%b addr=%h expected 1 %h", bus.imem_req, bus.imem_addr, prev_addr); end
         end
         if (bus.out_valid && !bus.pause) begin
            total++;
            if (bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
               begin bad++; $display("FAIL rand_stream pc=%h inst=%h expected %h %h", bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
            exp_pc += 4;
         end
         prev_req  = bus.imem_req;
         prev_rdy  = bus.imem_ready;
         prev_addr = bus.imem_addr;
      end
      next();
      bus.pause = 1'b0;
      rand_rdy  = 1'b0;
   endtask

   task automatic test_mid_reset();
      lat = 1;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b0, 32'h0, 1'b0, 32'h0, NOP})
         begin bad++; $display("FAIL async_reset req=%b addr=%h valid=%b pc=%h inst=%h", bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_pc, bus.out_inst); end
      next();
      next();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
         begin bad++; $display("FAIL restart_req req=%b addr=%h expected 1 00000000", bus.imem_req, bus.imem_addr); end
      next();
      next();
      @(negedge clk);
      exp_pc = 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin next(); @(negedge clk); end
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_inst !== word(exp_pc))
            begin bad++; $display("FAIL restart_stream valid=%b pc=%h inst=%h expected 1 %h %h", bus.out_valid, bus.out_pc, bus.out_inst, exp_pc, word(exp_pc)); end
         exp_pc += 4;
      end
   endtask

   initial begin
      bus.pause       = 1'b0;
      bus.jump        = 1'b0;
      bus.jump_addr   = '0;
      bus.imem_ready  = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      test_reset();
      test_stream();
      test_pause();
      test_jump_lat3();
      test_jump_pause();
      test_ready_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
